alu_issue_stage: RTL and testbench

//   Issue/writeback stage directly upstream of the 32-bit ALU (control/a/b -> c/zero).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_issue_stage_if.sv | 22 ++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue_stage.sv | 109 ++++++++++
 tb/tb_alu_issue_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, instruction field positions and decode helpers
// for the ALU issue stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake and result stream bundle of the ALU issue stage.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_instr;
  logic            res_valid;
  logic [3:0]      res_rd;
  logic [XLEN-1:0] res_data;
  logic            res_zero;

  modport master (
    output in_valid, in_instr,
    input  in_ready, res_valid, res_rd, res_data, res_zero
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, res_valid, res_rd, res_data, res_zero
  );
endinterface

// File: rtl/alu_regfile.sv
// NREG x XLEN register file: two async read ports, one debug read port,
// one synchronous write port. r0 reads zero and ignores writes.
module alu_regfile #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1      = (ra1 == '0)      ? '0 : regs[ra1];
  assign rd2      = (ra2 == '0)      ? '0 : regs[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a combinational 32-bit ALU: decodes,
// reads/forwards operands, registers ALU inputs and retires the ALU result.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus,
  output logic [3:0]        alu_control,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_c,
  input  logic              alu_zero,
  output logic              err,
  input  logic              clear_err,
  input  logic [3:0]        dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [3:0]      op, rd, rs1, rs2;
  logic [7:0]      imm;
  logic            accept, illegal, issue;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
  logic            ex_valid;
  logic [3:0]      ex_rd;
  logic            res_valid, res_zero;
  logic [3:0]      res_rd;
  logic [XLEN-1:0] res_data;

  assign op  = bus.in_instr[OP_MSB:OP_LSB];
  assign rd  = bus.in_instr[RD_MSB:RD_LSB];
  assign rs1 = bus.in_instr[RS1_MSB:RS1_LSB];
  assign rs2 = bus.in_instr[RS2_MSB:RS2_LSB];
  assign imm = bus.in_instr[IMM_MSB:IMM_LSB];

  assign bus.in_ready = !err;
  assign accept       = bus.in_valid && !err;
  assign illegal      = op[3] && (op[2:0] != 3'd0);
  assign issue        = accept && !illegal;

  alu_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(4)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (rs1),
    .rd1      (rf_rd1),
    .ra2      (rs2),
    .rd2      (rf_rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (ex_valid),
    .wa       (ex_rd),
    .wd       (alu_c)
  );

  // The instruction in EX retires on the same edge this one is accepted,
  // so its result is taken straight from the ALU output.
  always_comb begin
    rs1_val = rf_rd1;
    rs2_val = rf_rd2;
    if (ex_valid && (ex_rd == rs1) && (rs1 != '0)) rs1_val = alu_c;
    if (ex_valid && (ex_rd == rs2) && (rs2 != '0)) rs2_val = alu_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      res_valid   <= 1'b0;
      res_rd      <= '0;
      res_data    <= '0;
      res_zero    <= 1'b1;
      err         <= 1'b0;
    end else begin
      ex_valid <= issue;
      if (issue) begin
        ex_rd <= rd;
        if (op == OP_LDI) begin
          alu_control <= ALU_OR;
          alu_a       <= {{(XLEN-8){1'b0}}, imm};
          alu_b       <= '0;
        end else begin
          alu_control <= op;
          alu_a       <= rs1_val;
          alu_b       <= is_shift(op) ? {{(XLEN-5){1'b0}}, rs2_val[4:0]} : rs2_val;
        end
      end
      res_valid <= ex_valid;
      if (ex_valid) begin
        res_rd   <= ex_rd;
        res_data <= alu_c;
        res_zero <= alu_zero;
      end
      if (accept && illegal) err <= 1'b1;
      else if (clear_err)    err <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid;
  assign bus.res_rd    = res_rd;
  assign bus.res_data  = res_data;
  assign bus.res_zero  = res_zero;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench: alu_issue_stage driving a behavioural ALU.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        alu_zero;
  logic        err;
  logic        clear_err = 1'b0;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int tests = 0;
  int fails = 0;
  int res_count = 0;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32), .NREG(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_zero    (alu_zero),
    .err         (err),
    .clear_err   (clear_err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      4'd0: alu_c = alu_a & alu_b;
      4'd1: alu_c = alu_a | alu_b;
      4'd2: alu_c = alu_a + alu_b;
      4'd3: alu_c = alu_a ^ alu_b;
      4'd4: alu_c = alu_a << alu_b[4:0];
      4'd5: alu_c = alu_a >> alu_b[4:0];
      4'd6: alu_c = alu_a - alu_b;
      4'd7: alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_c = '0;
    endcase
    alu_zero = (alu_c == '0);
  end

  always @(posedge clk) if (bus.res_valid === 1'b1) res_count++;

  task automatic send(input logic [15:0] instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_addr = r[3:0];
    #1;
    v = dbg_data;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
    tests++; if (bus.res_zero !== 1'b1) begin fails++; $display("FAIL reset_res_zero got %b exp 1", bus.res_zero); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if ({alu_control, alu_a, alu_b} !== '0) begin fails++; $display("FAIL reset_alu_regs got %h/%h/%h exp 0", alu_control, alu_a, alu_b); end
    for (int i = 0; i < 16; i++) begin
      read_reg(i, v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_reg%0d got %h exp 0", i, v); end
    end
  endtask

  task automatic test_forward_and;
    logic [31:0] v;
    int c0 = res_count;
    send(16'h815A);
    send(16'h820F);
    tests++; if (bus.res_valid !== 1'b1 || bus.res_rd !== 4'd1 || bus.res_data !== 32'h5A) begin
      fails++; $display("FAIL ldi_r1_retire got v=%b rd=%0d d=%h exp 1/1/5a", bus.res_valid, bus.res_rd, bus.res_data); end
    send(16'h0312);
    tests++; if (alu_control !== 4'd0 || alu_a !== 32'h5A || alu_b !== 32'h0F) begin
      fails++; $display("FAIL and_issue got c=%0d a=%h b=%h exp 0/5a/0f", alu_control, alu_a, alu_b); end
    @(posedge clk); #1;
    tests++; if (bus.res_valid !== 1'b1 || bus.res_rd !== 4'd3 || bus.res_data !== 32'h0A || bus.res_zero !== 1'b0) begin
      fails++; $display("FAIL and_retire got v=%b rd=%0d d=%h z=%b exp 1/3/0a/0", bus.res_valid, bus.res_rd, bus.res_data, bus.res_zero); end
    read_reg(3, v);
    tests++; if (v !== 32'h0A) begin fails++; $display("FAIL and_reg3 got %h exp 0a", v); end
    @(posedge clk); #1;
    tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL res_pulse got %b exp 0", bus.res_valid); end
    tests++; if (res_count - c0 !== 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", res_count - c0); end
  endtask

  task automatic test_sub_zero;
    logic [31:0] v;
    send(16'h81FF);
    send(16'h6411);
    tests++; if (alu_a !== 32'hFF || alu_b !== 32'hFF) begin fails++; $display("FAIL sub_fwd got a=%h b=%h exp ff/ff", alu_a, alu_b); end
    @(posedge clk); #1;
    tests++; if (bus.res_rd !== 4'd4 || bus.res_data !== 32'h0 || bus.res_zero !== 1'b1) begin
      fails++; $display("FAIL sub_retire got rd=%0d d=%h z=%b exp 4/0/1", bus.res_rd, bus.res_data, bus.res_zero); end
    read_reg(1, v);
    tests++; if (v !== 32'hFF) begin fails++; $display("FAIL sub_reg1 got %h exp ff", v); end
  endtask

  task automatic test_shift_mask;
    logic [31:0] v;
    send(16'h8621);
    send(16'h8580);
    send(16'h4556);
    tests++; if (alu_control !== 4'd4 || alu_a !== 32'h80 || alu_b !== 32'h1) begin
      fails++; $display("FAIL sll_issue got c=%0d a=%h b=%h exp 4/80/1", alu_control, alu_a, alu_b); end
    @(posedge clk); #1;
    tests++; if (bus.res_data !== 32'h100 || bus.res_rd !== 4'd5) begin fails++; $display("FAIL sll_retire got rd=%0d d=%h exp 5/100", bus.res_rd, bus.res_data); end
    read_reg(5, v);
    tests++; if (v !== 32'h100) begin fails++; $display("FAIL sll_reg5 got %h exp 100", v); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    logic [31:0] v;
    int c0 = res_count;
    send(16'hA123);
    tests++; if (err !== 1'b1 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL illegal_err got err=%b rdy=%b exp 1/0", err, bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h8777;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tests++; if (res_count !== c0) begin fails++; $display("FAIL illegal_no_res got %0d exp %0d", res_count, c0); end
    tests++; if (alu_control !== 4'd4 || alu_b !== 32'h1) begin fails++; $display("FAIL illegal_hold got c=%0d b=%h exp 4/1", alu_control, alu_b); end
    read_reg(7, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL blocked_reg7 got %h exp 0", v); end
    read_reg(3, v);
    tests++; if (v !== 32'h0A) begin fails++; $display("FAIL illegal_reg3 got %h exp 0a", v); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got %b exp 1", err); end
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    tests++; if (err !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL clear_err got err=%b rdy=%b exp 0/1", err, bus.in_ready); end
  endtask

  task automatic test_ldi_r0;
    logic [31:0] v;
    send(16'h8033);
    @(posedge clk); #1;
    tests++; if (bus.res_valid !== 1'b1 || bus.res_rd !== 4'd0 || bus.res_data !== 32'h33) begin
      fails++; $display("FAIL r0_retire got v=%b rd=%0d d=%h exp 1/0/33", bus.res_valid, bus.res_rd, bus.res_data); end
    read_reg(0, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL r0_read got %h exp 0", v); end
  endtask

  task automatic test_wrap_sra;
    logic [31:0] v;
    send(16'h6A01);
    send(16'h7BA6);
    tests++; if (alu_control !== 4'd7 || alu_a !== 32'hFFFFFF01 || alu_b !== 32'h1) begin
      fails++; $display("FAIL sra_issue got c=%0d a=%h b=%h exp 7/ffffff01/1", alu_control, alu_a, alu_b); end
    @(posedge clk); #1;
    tests++; if (bus.res_rd !== 4'd11 || bus.res_data !== 32'hFFFFFF80) begin
      fails++; $display("FAIL sra_retire got rd=%0d d=%h exp 11/ffffff80", bus.res_rd, bus.res_data); end
    read_reg(10, v);
    tests++; if (v !== 32'hFFFFFF01) begin fails++; $display("FAIL wrap_reg10 got %h exp ffffff01", v); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int c0 = res_count;
    send(16'h2813);
    rst_n = 1'b0;
    #1;
    tests++; if ({alu_control, alu_a, alu_b} !== '0) begin fails++; $display("FAIL rst_alu_regs got %h/%h/%h exp 0", alu_control, alu_a, alu_b); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (res_count !== c0 || bus.res_valid !== 1'b0) begin fails++; $display("FAIL rst_drop got cnt=%0d v=%b exp %0d/0", res_count, bus.res_valid, c0); end
    tests++; if (bus.res_data !== 32'h0 || bus.res_zero !== 1'b1) begin fails++; $display("FAIL rst_res got d=%h z=%b exp 0/1", bus.res_data, bus.res_zero); end
    for (int i = 1; i < 16; i++) begin
      read_reg(i, v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_reg%0d got %h exp 0", i, v); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_forward_and;
    test_sub_zero;
    test_shift_mask;
    test_illegal;
    test_ldi_r0;
    test_wrap_sra;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
